// File: rtl/fir_mdc_out_packer.sv
// Packs pairs of narrowed FIR output samples into 32-bit words for the TCDM streamer.
// Define FIR_MDC_OUT_SAT_EN to saturate, rather than truncate, when narrowing to 16 bits.
module fir_mdc_out_packer #(
    parameter int IN_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic        [CNT_WIDTH-1:0] len_i,
    input  logic        [4:0]           shift_i,
    input  logic signed [IN_WIDTH-1:0]  in_data_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic        [31:0]          out_data_o,
    output logic        [3:0]           out_strb_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic        [CNT_WIDTH-1:0] cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       state;
    logic        [CNT_WIDTH-1:0]  len_r;
    logic        [4:0]            shift_r;
    logic        [CNT_WIDTH-1:0]  scnt_p0;
    logic        [CNT_WIDTH-1:0]  scnt_nxt;
    logic        [15:0]           half_p0;
    logic signed [IN_WIDTH-1:0]   shifted_p0;
    logic        [15:0]           lane_p0;
    logic                         in_hs;
    logic                         out_hs;
    logic                         last_p0;

    // Saturation only needs to know whether the bits above bit 15 are a pure sign extension.
    function automatic logic [15:0] narrow(input logic signed [IN_WIDTH-1:0] s);
`ifdef FIR_MDC_OUT_SAT_EN
        logic [IN_WIDTH-16:0] hi;
        hi = s[IN_WIDTH-1:15];
        if (hi != '0 && hi != '1) return s[IN_WIDTH-1] ? 16'h8000 : 16'h7FFF;
`endif
        return s[15:0];
    endfunction

    assign in_ready_o = (state == RUN) && (!out_valid_o || out_ready_i);
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_o && out_ready_i;
    assign busy_o     = (state != IDLE);
    assign shifted_p0 = in_data_i >>> shift_r;
    assign lane_p0    = narrow(shifted_p0);
    assign scnt_nxt   = scnt_p0 + CNT_WIDTH'(1);
    assign last_p0    = (scnt_nxt == len_r);

    // ---- stage p0 -> output register: half-word assembly and job control ----
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state       <= IDLE;
            len_r       <= '0;
            shift_r     <= '0;
            scnt_p0     <= '0;
            half_p0     <= '0;
            out_data_o  <= '0;
            out_strb_o  <= '0;
            out_valid_o <= 1'b0;
            done_o      <= 1'b0;
            cnt_o       <= '0;
        end else begin
            done_o <= 1'b0;
            if (out_hs) begin
                out_valid_o <= 1'b0;
                cnt_o       <= cnt_o + CNT_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_r   <= len_i;
                        shift_r <= shift_i;
                        scnt_p0 <= '0;
                        cnt_o   <= '0;
                        state   <= (len_i != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        scnt_p0 <= scnt_nxt;
                        if (scnt_p0[0]) begin
                            out_data_o  <= {lane_p0, half_p0};
                            out_strb_o  <= 4'b1111;
                            out_valid_o <= 1'b1;
                        end else if (last_p0) begin
                            out_data_o  <= {16'h0000, lane_p0};
                            out_strb_o  <= 4'b0011;
                            out_valid_o <= 1'b1;
                        end else begin
                            half_p0 <= lane_p0;
                        end
                        if (last_p0) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_hs) state <= DONE;
                end
                DONE: begin
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mdc_out_packer.sv
// Randomized bench for fir_mdc_out_packer against a sample-list packing model.
module tb_fir_mdc_out_packer;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               clear_i;
    logic               start_i;
    logic        [15:0] len_i;
    logic        [4:0]  shift_i;
    logic signed [31:0] in_data_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic        [31:0] out_data_o;
    logic        [3:0]  out_strb_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               busy_o;
    logic               done_o;
    logic        [15:0] cnt_o;

    fir_mdc_out_packer #(.IN_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .len_i(len_i), .shift_i(shift_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_strb_o(out_strb_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    bit          mon_en = 1'b0;
    logic [31:0] samples[$];
    logic [35:0] exp_q[$];

`ifdef FIR_MDC_OUT_SAT_EN
    localparam logic [15:0] BIG_LANE = 16'h7FFF;
`else
    localparam logic [15:0] BIG_LANE = 16'h2345;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Narrowing rule expressed with plain integer arithmetic.
    function automatic logic [15:0] m_narrow(input logic [31:0] x, input int sh);
        longint s;
        s = longint'($signed(x));
        s = s >>> sh;
`ifdef FIR_MDC_OUT_SAT_EN
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    task automatic model_fill(input int sh);
        int n;
        n = samples.size();
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n)
                exp_q.push_back({4'hF, m_narrow(samples[i+1], sh), m_narrow(samples[i], sh)});
            else
                exp_q.push_back({4'h3, 16'h0000, m_narrow(samples[i], sh)});
        end
    endtask

    task automatic gen_samples(input int n);
        logic [31:0] r;
        samples.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            case ($urandom_range(2))
                0: r = {{16{r[15]}}, r[15:0]};
                1: r = {{12{r[19]}}, r[19:0]};
                default: ;
            endcase
            samples.push_back(r);
        end
    endtask

    // Compare process: every output handshake is checked against the model queue.
    bit          stall_prev = 1'b0;
    logic [35:0] word_prev;
    bit          done_prev = 1'b0;
    logic [35:0] w;
    always @(negedge clk_i) begin
        #2;
        if (!mon_en) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", out_valid_o, 1);
                chk("stall_word_held", {out_strb_o, out_data_o}, word_prev);
            end
            if (out_valid_o && !out_ready_i) chk("in_ready_when_full", in_ready_o, 0);
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {out_strb_o, out_data_o}, 36'hF_FFFF_FFFF + 1);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", out_data_o, w[31:0]);
                    chk("word_strb", out_strb_o, w[35:32]);
                end
            end
            if (done_o) begin
                done_cnt++;
                if (done_prev) chk("done_single_pulse", 0, 1);
            end
            done_prev  = done_o;
            stall_prev = out_valid_o && !out_ready_i;
            word_prev  = {out_strb_o, out_data_o};
        end
    end

    task automatic drive_job(input int len, input int shft, input int vld_pct,
                             input int rdy_pct, input int stall_at);
        int idx, cyc, base;
        logic [15:0] l16;
        logic [4:0]  s5;
        l16 = 16'(len);
        s5  = 5'(shft);
        @(negedge clk_i);
        start_i = 1'b1; len_i = l16; shift_i = s5;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        chk("cnt_at_start", cnt_o, 0);
        chk("busy_at_start", busy_o, 1);
        base = done_cnt;
        if (len == 0) begin
            chk("len0_done_early", done_o, 0);
            @(negedge clk_i); #1;
            chk("len0_done_pulse", done_o, 1);
            chk("len0_no_valid", out_valid_o, 0);
            @(negedge clk_i); #1;
            chk("len0_done_clear", done_o, 0);
            chk("len0_cnt", cnt_o, 0);
            return;
        end
        idx = 0; cyc = 0;
        while (done_cnt == base && cyc < 3000) begin
            in_valid_i  = (idx < len) && ($urandom_range(99) < vld_pct);
            in_data_i   = in_valid_i ? samples[idx] : $urandom;
            out_ready_i = ($urandom_range(99) < rdy_pct) &&
                          !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10);
            #1;
            if (in_valid_i && in_ready_o) idx++;
            @(negedge clk_i);
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        chk("job_finished", done_cnt != base, 1);
        chk("cnt_final", cnt_o, (len + 1) / 2);
        chk("words_left", exp_q.size(), 0);
        chk("samples_taken", idx, len);
    endtask

    task automatic random_job();
        int len, sh;
        len = $urandom_range(40, 1);
        sh  = ($urandom_range(3) == 0) ? $urandom_range(31) : 0;
        gen_samples(len);
        model_fill(sh);
        drive_job(len, sh, $urandom_range(100, 30), $urandom_range(100, 30), -1);
    endtask

    task automatic abort_job(input bit use_rst);
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        start_i = 1'b1; len_i = 16'd8; shift_i = 5'd0;
        @(negedge clk_i);
        start_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_data_i = $urandom;
            @(negedge clk_i);
        end
        #1;
        chk("abort_word_pending", out_valid_o, 1);
        @(negedge clk_i);
        if (use_rst) rst_i = 1'b1; else clear_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; clear_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", out_valid_o, 0);
        chk("abort_data", out_data_o, 0);
        chk("abort_strb", out_strb_o, 0);
        chk("abort_cnt", cnt_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_in_ready", in_ready_o, 0);
        mon_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0; shift_i = '0;
        in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_strb", out_strb_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", cnt_o, 0);
        rst_i = 1'b0;

        chk("model_pin_big", m_narrow(32'h00012345, 0), BIG_LANE);
        chk("model_pin_shift", m_narrow(32'hFFFFF000, 4), 16'hFF00);

        mon_en = 1'b1;

        samples = '{32'd1, 32'd2, 32'd3, 32'd4};
        exp_q.push_back({4'hF, 32'h00020001});
        exp_q.push_back({4'hF, 32'h00040003});
        drive_job(4, 0, 100, 100, -1);

        samples = '{32'd5, 32'd6, 32'd7};
        exp_q.push_back({4'hF, 32'h00060005});
        exp_q.push_back({4'h3, 32'h00000007});
        drive_job(3, 0, 100, 100, -1);

        samples = '{32'h00012345};
        exp_q.push_back({4'h3, 16'h0000, BIG_LANE});
        drive_job(1, 0, 100, 100, -1);

        samples = '{32'hFFFFF000};
        exp_q.push_back({4'h3, 32'h0000FF00});
        drive_job(1, 4, 100, 100, -1);

        gen_samples(12);
        model_fill(0);
        drive_job(12, 0, 100, 100, 3);

        drive_job(0, 0, 100, 100, -1);

        @(negedge clk_i);
        clear_i = 1'b1; start_i = 1'b1; len_i = 16'd4;
        @(negedge clk_i);
        clear_i = 1'b0; start_i = 1'b0;
        #1;
        chk("clear_beats_start", busy_o, 0);

        abort_job(1'b0);
        random_job();
        abort_job(1'b1);
        random_job();

        for (int j = 0; j < 10; j++) random_job();

        repeat (2) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
